// File: rtl/dsp_sys_bus_master_if.sv
// Command, response and DSP system bus signals of dsp_sys_bus_master.
// master is the bus master's own view; slave is the command source, response sink and bus responder.
interface dsp_sys_bus_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        busy;
  logic [31:0] sys_addr;
  logic [31:0] sys_wdata;
  logic [3:0]  sys_sel;
  logic        sys_wen;
  logic        sys_ren;
  logic [31:0] sys_rdata;
  logic        sys_ack;
  logic        sys_err;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
           sys_rdata, sys_ack, sys_err,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy,
           sys_addr, sys_wdata, sys_sel, sys_wen, sys_ren
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
           sys_rdata, sys_ack, sys_err,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy,
           sys_addr, sys_wdata, sys_sel, sys_wen, sys_ren
  );
endinterface

// File: rtl/dsp_sys_bus_master.sv
// Single-outstanding DSP system bus initiator: one bus transaction per command,
// one response per transaction, with an ack timeout so unmapped addresses cannot hang it.
module dsp_sys_bus_master #(
  parameter int TIMEOUT = 64,
  parameter int CW      = $clog2(TIMEOUT + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  dsp_sys_bus_master_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STROBE = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);
  localparam logic [CW-1:0] ONE_C     = CW'(1);

  state_t        state_r;
  state_t        state_nxt_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_inc_s;
  logic          write_r;
  logic [31:0]   sys_addr_r;
  logic [31:0]   sys_wdata_r;
  logic [3:0]    sys_sel_r;
  logic          sys_wen_r;
  logic          sys_ren_r;
  logic          rsp_valid_r;
  logic [31:0]   rsp_rdata_r;
  logic          rsp_err_r;
  logic          rsp_timeout_r;
  logic          cmd_ready_s;
  logic          busy_s;
  logic          accept_s;
  logic          ack_s;
  logic          expire_s;
  logic          rsp_done_s;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE:   state_nxt_s = accept_s ? ST_STROBE : ST_IDLE;
      ST_STROBE: state_nxt_s = ST_WAIT;
      ST_WAIT:   state_nxt_s = (ack_s || expire_s) ? ST_RESP : ST_WAIT;
      ST_RESP:   state_nxt_s = rsp_done_s ? ST_IDLE : ST_RESP;
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  // Output decode: handshake readiness and the per-state events that steer the datapath
  always_comb begin
    cmd_ready_s = 1'b0;
    busy_s      = 1'b1;
    accept_s    = 1'b0;
    ack_s       = 1'b0;
    expire_s    = 1'b0;
    rsp_done_s  = 1'b0;
    cnt_inc_s   = cnt_r + ONE_C;
    case (state_r)
      ST_IDLE: begin
        cmd_ready_s = 1'b1;
        busy_s      = 1'b0;
        accept_s    = bus.cmd_valid;
      end
      ST_WAIT: begin
        // An ack on the final cycle beats the timeout.
        ack_s    = bus.sys_ack;
        expire_s = !bus.sys_ack && (cnt_inc_s == TIMEOUT_C);
      end
      ST_RESP: begin
        rsp_done_s = bus.rsp_ready;
      end
      default: begin
        cmd_ready_s = 1'b0;
        busy_s      = 1'b1;
      end
    endcase
  end

  // Bus drive, timeout counter and response capture
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      write_r       <= 1'b0;
      cnt_r         <= {CW{1'b0}};
      sys_addr_r    <= 32'h0000_0000;
      sys_wdata_r   <= 32'h0000_0000;
      sys_sel_r     <= 4'h0;
      sys_wen_r     <= 1'b0;
      sys_ren_r     <= 1'b0;
      rsp_valid_r   <= 1'b0;
      rsp_rdata_r   <= 32'h0000_0000;
      rsp_err_r     <= 1'b0;
      rsp_timeout_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            write_r    <= bus.cmd_write;
            sys_addr_r <= bus.cmd_addr;
            sys_wen_r  <= bus.cmd_write;
            sys_ren_r  <= !bus.cmd_write;
            if (bus.cmd_write) begin
              sys_wdata_r <= bus.cmd_wdata;
              sys_sel_r   <= 4'hF;
            end else begin
              sys_sel_r   <= 4'h0;
            end
          end
        end
        ST_STROBE: begin
          sys_wen_r <= 1'b0;
          sys_ren_r <= 1'b0;
          cnt_r     <= {CW{1'b0}};
        end
        ST_WAIT: begin
          if (ack_s) begin
            rsp_rdata_r   <= write_r ? 32'h0000_0000 : bus.sys_rdata;
            rsp_err_r     <= bus.sys_err;
            rsp_timeout_r <= 1'b0;
            rsp_valid_r   <= 1'b1;
          end else if (expire_s) begin
            rsp_rdata_r   <= 32'h0000_0000;
            rsp_err_r     <= 1'b1;
            rsp_timeout_r <= 1'b1;
            rsp_valid_r   <= 1'b1;
            cnt_r         <= cnt_inc_s;
          end else begin
            cnt_r <= cnt_inc_s;
          end
        end
        ST_RESP: begin
          if (rsp_done_s) begin
            rsp_valid_r <= 1'b0;
          end
        end
        default: begin
          sys_wen_r <= 1'b0;
          sys_ren_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready   = cmd_ready_s;
  assign bus.busy        = busy_s;
  assign bus.sys_addr    = sys_addr_r;
  assign bus.sys_wdata   = sys_wdata_r;
  assign bus.sys_sel     = sys_sel_r;
  assign bus.sys_wen     = sys_wen_r;
  assign bus.sys_ren     = sys_ren_r;
  assign bus.rsp_valid   = rsp_valid_r;
  assign bus.rsp_rdata   = rsp_rdata_r;
  assign bus.rsp_err     = rsp_err_r;
  assign bus.rsp_timeout = rsp_timeout_r;

endmodule

// File: tb/tb_dsp_sys_bus_master.sv
// Bench for dsp_sys_bus_master: a default-TIMEOUT instance (dut_a) and a TIMEOUT=4 instance (dut_b)
// share one stimulus set; sel routes the handshakes to one of them. Responses are scoreboarded.
module tb_dsp_sys_bus_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        cmd_valid;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_ready;
  logic [31:0] sys_rdata;
  logic        sys_ack;
  logic        sys_err;

  int checks   = 0;
  int failures = 0;

  // Expected response: {rdata, err, timeout}
  logic [33:0] exp_q[$];
  logic [33:0] exp_r;

  localparam logic [106:0] RST_OUTS = {1'b1, 106'd0};

  always #5 clk = ~clk;

  dsp_sys_bus_master_if bus_a ();
  dsp_sys_bus_master_if bus_b ();

  dsp_sys_bus_master #(.TIMEOUT(64)) dut_a (.clk_i(clk), .rst_i(rst), .bus(bus_a));
  dsp_sys_bus_master #(.TIMEOUT(4))  dut_b (.clk_i(clk), .rst_i(rst), .bus(bus_b));

  assign bus_a.cmd_valid = cmd_valid & ~sel;
  assign bus_b.cmd_valid = cmd_valid & sel;
  assign bus_a.rsp_ready = rsp_ready & ~sel;
  assign bus_b.rsp_ready = rsp_ready & sel;
  assign bus_a.sys_ack   = sys_ack & ~sel;
  assign bus_b.sys_ack   = sys_ack & sel;
  assign bus_a.cmd_write = cmd_write;
  assign bus_b.cmd_write = cmd_write;
  assign bus_a.cmd_addr  = cmd_addr;
  assign bus_b.cmd_addr  = cmd_addr;
  assign bus_a.cmd_wdata = cmd_wdata;
  assign bus_b.cmd_wdata = cmd_wdata;
  assign bus_a.sys_rdata = sys_rdata;
  assign bus_b.sys_rdata = sys_rdata;
  assign bus_a.sys_err   = sys_err;
  assign bus_b.sys_err   = sys_err;

  logic [106:0] outs_a, outs_b, outs_s;
  assign outs_a = {bus_a.cmd_ready, bus_a.rsp_valid, bus_a.rsp_rdata, bus_a.rsp_err, bus_a.rsp_timeout,
                   bus_a.busy, bus_a.sys_addr, bus_a.sys_wdata, bus_a.sys_sel, bus_a.sys_wen, bus_a.sys_ren};
  assign outs_b = {bus_b.cmd_ready, bus_b.rsp_valid, bus_b.rsp_rdata, bus_b.rsp_err, bus_b.rsp_timeout,
                   bus_b.busy, bus_b.sys_addr, bus_b.sys_wdata, bus_b.sys_sel, bus_b.sys_wen, bus_b.sys_ren};
  assign outs_s = sel ? outs_b : outs_a;

  logic        o_cmd_ready, o_rsp_valid, o_rsp_err, o_rsp_timeout, o_busy, o_sys_wen, o_sys_ren;
  logic [31:0] o_rsp_rdata, o_sys_addr, o_sys_wdata;
  logic [3:0]  o_sys_sel;
  assign {o_cmd_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err, o_rsp_timeout,
          o_busy, o_sys_addr, o_sys_wdata, o_sys_sel, o_sys_wen, o_sys_ren} = outs_s;

  task automatic test_reset();
    rst = 1'b1; sel = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
    cmd_addr = 32'h0; cmd_wdata = 32'h0; rsp_ready = 1'b0;
    sys_rdata = 32'h0; sys_ack = 1'b0; sys_err = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (outs_a !== RST_OUTS) begin failures++; $display("FAIL reset_a: got %h expected %h", outs_a, RST_OUTS); end
    checks++;
    if (outs_b !== RST_OUTS) begin failures++; $display("FAIL reset_b: got %h expected %h", outs_b, RST_OUTS); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write();
    sel = 1'b0; rsp_ready = 1'b1; sys_rdata = 32'h1234_5678;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h4030_0004; cmd_wdata = 32'h0000_0002;
    checks++;
    if (o_cmd_ready !== 1'b1) begin failures++; $display("FAIL write_ready: got %b expected 1", o_cmd_ready); end
    exp_q.push_back({32'h0, 1'b0, 1'b0});
    @(negedge clk);  // strobe cycle
    cmd_valid = 1'b0;
    checks++;
    if ({o_sys_wen, o_sys_ren, o_sys_sel, o_sys_addr, o_sys_wdata, o_busy, o_cmd_ready} !==
        {1'b1, 1'b0, 4'hF, 32'h4030_0004, 32'h0000_0002, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL write_strobe: wen=%b ren=%b sel=%h addr=%h wdata=%h busy=%b rdy=%b expected 1 0 f 40300004 00000002 1 0",
               o_sys_wen, o_sys_ren, o_sys_sel, o_sys_addr, o_sys_wdata, o_busy, o_cmd_ready);
    end
    @(negedge clk);  // first wait cycle: registered responder acks now
    sys_ack = 1'b1;
    checks++;
    if ({o_sys_wen, o_sys_ren, o_rsp_valid} !== 3'b000) begin
      failures++; $display("FAIL write_strobe_len: wen/ren/rsp_valid got %b expected 000", {o_sys_wen, o_sys_ren, o_rsp_valid});
    end
    @(negedge clk);  // accept + 3
    sys_ack = 1'b0;
    exp_r = exp_q.pop_front();
    checks++;
    if ({o_rsp_valid, o_rsp_rdata, o_rsp_err, o_rsp_timeout} !== {1'b1, exp_r}) begin
      failures++; $display("FAIL write_rsp: got %h expected %h", {o_rsp_valid, o_rsp_rdata, o_rsp_err, o_rsp_timeout}, {1'b1, exp_r});
    end
    @(negedge clk);
    checks++;
    if ({o_rsp_valid, o_busy, o_cmd_ready, o_sys_wen, o_sys_sel, o_sys_addr} !== {1'b0, 1'b0, 1'b1, 1'b0, 4'hF, 32'h4030_0004}) begin
      failures++; $display("FAIL write_idle: got %h expected %h", {o_rsp_valid, o_busy, o_cmd_ready, o_sys_wen, o_sys_sel, o_sys_addr},
                           {1'b0, 1'b0, 1'b1, 1'b0, 4'hF, 32'h4030_0004});
    end
  endtask

  task automatic test_read();
    int lat, ren_n, wen_n;
    sel = 1'b0; rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h4030_0000; cmd_wdata = 32'hFFFF_FFFF;
    exp_q.push_back({32'h0000_000A, 1'b0, 1'b0});
    @(negedge clk);  // strobe cycle
    cmd_valid = 1'b0;
    lat = 0; ren_n = 0; wen_n = 0;
    while (!o_rsp_valid && lat < 40) begin
      if (o_sys_ren === 1'b1) ren_n++;
      if (o_sys_wen === 1'b1) wen_n++;
      sys_ack   = (lat == 6);
      sys_rdata = (lat == 6) ? 32'h0000_000A : 32'hDEAD_BEEF;
      @(negedge clk);
      lat++;
    end
    sys_ack = 1'b0;
    checks++;
    if (lat !== 7) begin failures++; $display("FAIL read_latency: got %0d expected 7", lat); end
    checks++;
    if (ren_n !== 1 || wen_n !== 0) begin failures++; $display("FAIL read_strobes: ren=%0d wen=%0d expected 1 0", ren_n, wen_n); end
    checks++;
    if ({o_sys_sel, o_sys_wdata, o_sys_addr} !== {4'h0, 32'h0000_0002, 32'h4030_0000}) begin
      failures++; $display("FAIL read_bus_hold: got %h expected %h", {o_sys_sel, o_sys_wdata, o_sys_addr}, {4'h0, 32'h0000_0002, 32'h4030_0000});
    end
    exp_r = exp_q.pop_front();
    checks++;
    if ({o_rsp_valid, o_rsp_rdata, o_rsp_err, o_rsp_timeout} !== {1'b1, exp_r}) begin
      failures++; $display("FAIL read_rsp: got %h expected %h", {o_rsp_valid, o_rsp_rdata, o_rsp_err, o_rsp_timeout}, {1'b1, exp_r});
    end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int lat;
    logic [106:0] snap;
    sel = 1'b1; rsp_ready = 1'b0; sys_ack = 1'b0; sys_err = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h5000_0000;
    exp_q.push_back({32'h0, 1'b1, 1'b1});
    @(negedge clk);  // strobe cycle
    cmd_valid = 1'b0;
    lat = 0;
    while (!o_rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 5) begin failures++; $display("FAIL timeout_latency: got %0d expected 5", lat); end
    exp_r = exp_q.pop_front();
    checks++;
    if ({o_rsp_valid, o_rsp_rdata, o_rsp_err, o_rsp_timeout} !== {1'b1, exp_r}) begin
      failures++; $display("FAIL timeout_rsp: got %h expected %h", {o_rsp_valid, o_rsp_rdata, o_rsp_err, o_rsp_timeout}, {1'b1, exp_r});
    end
    snap = outs_s;
    sys_ack = 1'b1; sys_err = 1'b1; sys_rdata = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    checks++;
    if (outs_s !== snap) begin failures++; $display("FAIL late_ack_resp: got %h expected %h", outs_s, snap); end
    sys_ack = 1'b0; sys_err = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    snap = outs_s;
    sys_ack = 1'b1;
    repeat (2) @(negedge clk);
    sys_ack = 1'b0;
    checks++;
    if (outs_s !== snap || o_busy !== 1'b0) begin failures++; $display("FAIL stray_ack_idle: got %h expected %h", outs_s, snap); end
  endtask

  task automatic test_error();
    sel = 1'b0; rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h4030_0010;
    exp_q.push_back({32'h0000_1234, 1'b1, 1'b0});
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    sys_ack = 1'b1; sys_err = 1'b1; sys_rdata = 32'h0000_1234;
    @(negedge clk);
    sys_ack = 1'b0; sys_err = 1'b0;
    exp_r = exp_q.pop_front();
    checks++;
    if ({o_rsp_valid, o_rsp_rdata, o_rsp_err, o_rsp_timeout} !== {1'b1, exp_r}) begin
      failures++; $display("FAIL err_rsp: got %h expected %h", {o_rsp_valid, o_rsp_rdata, o_rsp_err, o_rsp_timeout}, {1'b1, exp_r});
    end
    @(negedge clk);
  endtask

  task automatic test_ack_at_timeout();
    int lat;
    sel = 1'b1; rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h4030_0014;
    exp_q.push_back({32'h0000_B0B0, 1'b0, 1'b0});
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 0;
    while (!o_rsp_valid && lat < 20) begin
      sys_ack   = (lat == 4);
      sys_rdata = (lat == 4) ? 32'h0000_B0B0 : 32'h0;
      @(negedge clk);
      lat++;
    end
    sys_ack = 1'b0;
    checks++;
    if (lat !== 5) begin failures++; $display("FAIL boundary_latency: got %0d expected 5", lat); end
    exp_r = exp_q.pop_front();
    checks++;
    if ({o_rsp_valid, o_rsp_rdata, o_rsp_err, o_rsp_timeout} !== {1'b1, exp_r}) begin
      failures++; $display("FAIL boundary_rsp: got %h expected %h", {o_rsp_valid, o_rsp_rdata, o_rsp_err, o_rsp_timeout}, {1'b1, exp_r});
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [106:0] snap;
    bit stable;
    sel = 1'b0; rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h4030_0008; cmd_wdata = 32'h0000_0055;
    exp_q.push_back({32'h0, 1'b0, 1'b0});
    @(negedge clk);  // strobe; second command presented and held
    cmd_write = 1'b0; cmd_addr = 32'h4030_000C;
    @(negedge clk);
    sys_ack = 1'b1; sys_rdata = 32'h0000_0077;
    @(negedge clk);
    sys_ack = 1'b0;
    exp_r = exp_q.pop_front();
    checks++;
    if ({o_rsp_valid, o_rsp_rdata, o_rsp_err, o_rsp_timeout} !== {1'b1, exp_r}) begin
      failures++; $display("FAIL bp_first_rsp: got %h expected %h", {o_rsp_valid, o_rsp_rdata, o_rsp_err, o_rsp_timeout}, {1'b1, exp_r});
    end
    snap = outs_s; stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (outs_s !== snap) stable = 1'b0;
    end
    checks++;
    if (!stable || o_cmd_ready !== 1'b0) begin failures++; $display("FAIL bp_hold: got %h expected %h", outs_s, snap); end
    exp_q.push_back({32'h0000_0077, 1'b0, 1'b0});
    rsp_ready = 1'b1;
    @(negedge clk);  // handshake taken; command must not be accepted yet
    checks++;
    if ({o_cmd_ready, o_busy, o_rsp_valid, o_sys_ren} !== 4'b1000) begin
      failures++; $display("FAIL bp_no_same_cycle: got %b expected 1000", {o_cmd_ready, o_busy, o_rsp_valid, o_sys_ren});
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if ({o_sys_ren, o_sys_wen, o_sys_sel, o_sys_addr} !== {1'b1, 1'b0, 4'h0, 32'h4030_000C}) begin
      failures++; $display("FAIL bp_second_accept: got %h expected %h", {o_sys_ren, o_sys_wen, o_sys_sel, o_sys_addr},
                           {1'b1, 1'b0, 4'h0, 32'h4030_000C});
    end
    @(negedge clk);
    sys_ack = 1'b1;
    @(negedge clk);
    sys_ack = 1'b0;
    exp_r = exp_q.pop_front();
    checks++;
    if ({o_rsp_valid, o_rsp_rdata, o_rsp_err, o_rsp_timeout} !== {1'b1, exp_r}) begin
      failures++; $display("FAIL bp_second_rsp: got %h expected %h", {o_rsp_valid, o_rsp_rdata, o_rsp_err, o_rsp_timeout}, {1'b1, exp_r});
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit seen;
    sel = 1'b0; rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h4030_0018;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);  // in WAIT, no ack
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (outs_s !== RST_OUTS) begin failures++; $display("FAIL reset_mid: got %h expected %h", outs_s, RST_OUTS); end
    seen = 1'b0;
    sys_ack = 1'b1; sys_rdata = 32'h0000_0BAD;
    repeat (6) begin
      @(negedge clk);
      sys_ack = 1'b0;
      if (o_rsp_valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin failures++; $display("FAIL reset_mid_no_rsp: got rsp_valid 1 expected 0"); end
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h4030_0020; cmd_wdata = 32'h0000_CAFE;
    exp_q.push_back({32'h0, 1'b0, 1'b0});
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if ({o_sys_wen, o_sys_sel, o_sys_addr, o_sys_wdata} !== {1'b1, 4'hF, 32'h4030_0020, 32'h0000_CAFE}) begin
      failures++; $display("FAIL reset_mid_fresh_strobe: got %h expected %h", {o_sys_wen, o_sys_sel, o_sys_addr, o_sys_wdata},
                           {1'b1, 4'hF, 32'h4030_0020, 32'h0000_CAFE});
    end
    @(negedge clk);
    sys_ack = 1'b1;
    @(negedge clk);
    sys_ack = 1'b0;
    exp_r = exp_q.pop_front();
    checks++;
    if ({o_rsp_valid, o_rsp_rdata, o_rsp_err, o_rsp_timeout} !== {1'b1, exp_r}) begin
      failures++; $display("FAIL reset_mid_fresh_rsp: got %h expected %h", {o_rsp_valid, o_rsp_rdata, o_rsp_err, o_rsp_timeout}, {1'b1, exp_r});
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_error();
    test_ack_at_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
